key_expansion_seq: RTL and testbench
====================================

# key_expansion_seq

Iterative AES key-schedule generator that produces one 32-bit schedule word per clock. It sits directly upstream of the Encrypt/Decrypt round engines. It delivers the same flat `(NR+1)*128`-bit expansion bus as the combinational `keyExpansion`, at a fraction of the area. One instance per key size (128/192/256). A `valid` flag tells the round engines when the bus is complete and stable.

## Interface
- `NK`, default 4, key length in 32-bit words; legal values are 4, 6, 8.
- `NR`, default 10, number of rounds; must equal `NK+6`.
- `clk`, input, 1, single clock; all state changes on the rising edge.
- `reset`, input, 1, synchronous, active-high; clears all state.
- `start`, input, 1, request a new expansion; sampled only when idle.
- `key_in`, input, NK*32, cipher key; word 0 is in the MSBs.
- `busy`, output, 1, high while schedule words are being generated.
- `done`, output, 1, one-cycle pulse when the last word has been written.
- `valid`, output, 1, high while `expansion` holds a complete schedule.
- `expansion`, output, (NR+1)*128, schedule words w[0..T-1] with T=4*(NR+1); w[i] sits at bits [(T-i)*32-1 -: 32], so w[0] is in the MSBs. Identical layout to `keyExpansion`.

## Operation
- **States:**
  - IDLE → LOAD on `start`.
  - LOAD → GEN unconditionally.
  - GEN → IDLE after w[T-1] is written.
  - LOAD is merged into the start edge; see Timing.
- **Start sampled in IDLE:**
  - w[0..NK-1] are loaded from `key_in`.
  - `valid` clears.
  - Word index i is set to NK.
  - Sub-index j = i mod NK is set to 0 (kept as a counter; no divider).
  - `rcon` is set to 8'h01.
  - `busy` is set to 1.
- **GEN, each cycle writes w[i] = w[i-NK] ^ temp:**
  - If j==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon ← xtime(rcon). The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Else if NK==8 and j==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - Then i ← i+1; j wraps from NK-1 to 0.
- **SubWord:** applies the FIPS-197 forward S-box to each byte. The block holds its own 256-entry LUT and uses 4 parallel lookups, combinational within the cycle.
- **Last word:** when i==T-1 is written, `busy` ← 0, `done` ← 1 for one cycle, `valid` ← 1.
- **Output stability:** `expansion` words not yet written hold their previous contents. Consumers must gate on `valid`.
- **`key_in` sampling:** sampled only on the accepted `start` edge; later changes are ignored until the next start.

## Timing
- **Reset values:** `busy`=0, `done`=0, `valid`=0, `expansion`=0, i=0, j=0, `rcon`=01, state IDLE.
- **Latency from start edge E:**
  - Words are generated at edges E+1 … E+(T-NK).
  - `done` is high in the cycle after edge E+(T-NK).
  - Resulting `done` latency: 40 cycles for NK=4, 46 for NK=6, 52 for NK=8.
- **`start` while busy:** ignored; no restart and no effect on the schedule.
- **`start` in the cycle `done` is high:** accepted, because the block is already idle. `valid` drops at that edge and a new schedule begins.
- **`reset` together with `start`:** `reset` wins; the block stays IDLE with all outputs 0.
- **`reset` mid-GEN:** the next cycle shows all reset values, with no `done` pulse. A later `start` runs the full sequence from scratch.
- **Back-to-back runs:** `done` pulses exactly once per accepted start.
- **Idle behaviour:** `valid` stays high indefinitely while idle.

## Test plan
- **128-bit schedule:**
  - Stimulus: NK=4, `key_in`=000102030405060708090a0b0c0d0e0f, `start` for 1 cycle.
  - Required response: `done` 40 cycles after the start edge.
  - Bits [1279:1152] equal the key.
  - w[4..7]=d6aa74fd d2af72fa daa678f1 d6ab76fe.
  - w[40..43]=13111d7f e3944a17 f307a78b 4d2b30c5.
  - Entire bus equals the `keyExpansion#(4,10)` output.
- **192-bit schedule:**
  - Stimulus: NK=6, key 000102…1617.
  - Required response: `done` at 46 cycles; w[48..51]=a4970a33 1a78dc09 c418c271 e3a41d5d; bus matches `keyExpansion#(6,12)`.
- **256-bit schedule (exercises the j==4 SubWord path):**
  - Stimulus: NK=8, key 000102…1e1f.
  - Required response: `done` at 52 cycles; w[56..59]=24fc79cc bf0979e9 371ac23c 6d68de36.
- **`start` pulsed again mid-run:**
  - Stimulus: NK=4 run; at cycle 10 of GEN, pulse `start` with a different `key_in`.
  - Required response: ignored; same final bus as the first test; exactly one `done`.
- **`reset` mid-run:**
  - Stimulus: assert `reset` at cycle 20 of GEN; release it, then `start`.
  - Required response: cycle after reset shows `busy`=`done`=`valid`=0 and `expansion`=0; the new run completes correctly in 40 cycles.
- **Restart on the `done` cycle:**
  - Stimulus: `start` asserted in the `done` cycle, new key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required response: `valid` drops the next cycle; second `done` 40 cycles later; w[43]=b6630ca6.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Iterative AES key-schedule generator: one 32-bit schedule word per clock.
// Produces the same flat (NR+1)*128-bit expansion bus as the combinational
// key expander, with w[0] in the MSBs, and raises valid once it is complete.
module key_expansion_seq #(
    parameter int NK = 4,   // key length in 32-bit words: 4, 6 or 8
    parameter int NR = 10   // number of rounds, NK+6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NK*32-1:0]        key_in,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [(NR+1)*128-1:0]   expansion
);

    // Total number of schedule words and the width of the word index.
    localparam int T  = 4 * (NR + 1);
    localparam int IW = $clog2(T + 1);

    // FIPS-197 forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // The load step is folded into the accepted start edge, so only two
    // states are needed: waiting for start, and generating words.
    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         state;
    state_t         next_state;
    logic           load_key;     // start accepted this cycle
    logic           last_word;    // writing w[T-1] this cycle

    logic [31:0]    w [T];        // schedule word storage
    logic [IW-1:0]  word_idx;     // i: index of the word being written
    logic [2:0]     sub_idx;      // j: i mod NK, kept as a wrapping counter
    logic [7:0]     rcon;

    logic [IW-1:0]  prev_idx;
    logic [IW-1:0]  back_idx;
    logic [31:0]    prev_word;    // w[i-1]
    logic [31:0]    back_word;    // w[i-NK]
    logic [31:0]    temp;
    logic [31:0]    new_word;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: accept start only when idle, finish on the last word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves it unassigned and no latch is inferred.
        next_state = state;
        load_key   = 1'b0;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = GEN;
                    load_key   = 1'b1;
                end
            end
            GEN: begin
                if (word_idx == IW'(T - 1)) begin
                    next_state = IDLE;
                    last_word  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Word generator: w[i] = w[i-NK] ^ temp, with temp chosen by the position j.
    always_comb begin
        prev_idx  = (state == GEN) ? word_idx - IW'(1)  : '0;
        back_idx  = (state == GEN) ? word_idx - IW'(NK) : '0;
        prev_word = w[prev_idx];
        back_word = w[back_idx];
        if (sub_idx == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if ((NK == 8) && (sub_idx == 3'd4)) begin
            temp = sub_word(prev_word);
        end else begin
            temp = prev_word;
        end
        new_word = back_word ^ temp;
    end

    // Schedule storage, counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the word store is cleared on reset because the expansion bus
            // is required to read as all zeros after reset, not just be ignored.
            for (int k = 0; k < T; k++) w[k] <= '0;
            word_idx <= '0;
            sub_idx  <= '0;
            rcon     <= 8'h01;
            done     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            done <= last_word;
            if (load_key) begin
                for (int k = 0; k < NK; k++) w[k] <= key_in[(NK - k) * 32 - 1 -: 32];
                word_idx <= IW'(NK);
                sub_idx  <= '0;
                rcon     <= 8'h01;
                valid    <= 1'b0;
            end else if (state == GEN) begin
                w[word_idx] <= new_word;
                word_idx    <= word_idx + IW'(1);
                sub_idx     <= (sub_idx == 3'(NK - 1)) ? 3'd0 : sub_idx + 3'd1;
                if (sub_idx == 3'd0) rcon <= xtime(rcon);
                if (last_word) valid <= 1'b1;
            end
        end
    end

    assign busy = (state == GEN);

    // Flatten the word store onto the bus, w[0] in the MSBs.
    for (genvar g = 0; g < T; g++) begin : g_bus
        assign expansion[(T - g) * 32 - 1 -: 32] = w[g];
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: one instance per key size, FIPS-197
// reference words as expected values.
module tb_key_expansion_seq;

    logic          clk;
    logic          reset;
    logic          start4, start6, start8;
    logic [127:0]  key4;
    logic [191:0]  key6;
    logic [255:0]  key8;
    logic          busy4, busy6, busy8;
    logic          done4, done6, done8;
    logic          valid4, valid6, valid8;
    logic [1407:0] exp4;
    logic [1663:0] exp6;
    logic [1919:0] exp8;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expansion_seq #(.NK(4), .NR(10)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .key_in(key4),
        .busy(busy4), .done(done4), .valid(valid4), .expansion(exp4)
    );
    key_expansion_seq #(.NK(6), .NR(12)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .key_in(key6),
        .busy(busy6), .done(done6), .valid(valid6), .expansion(exp6)
    );
    key_expansion_seq #(.NK(8), .NR(14)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .key_in(key8),
        .busy(busy8), .done(done8), .valid(valid8), .expansion(exp8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_word(input int sel, input int k);
        case (sel)
            4:       return exp4[(44 - k) * 32 - 1 -: 32];
            6:       return exp6[(52 - k) * 32 - 1 -: 32];
            default: return exp8[(60 - k) * 32 - 1 -: 32];
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            4:       return done4;
            6:       return done6;
            default: return done8;
        endcase
    endfunction

    // One-cycle start pulse; the key is taken from the low bits of key.
    task automatic do_start(input int sel, input logic [255:0] key);
        case (sel)
            4:       begin key4 = key[127:0]; start4 = 1'b1; end
            6:       begin key6 = key[191:0]; start6 = 1'b1; end
            default: begin key8 = key;        start8 = 1'b1; end
        endcase
        tick();
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    // Cycles from the start edge until done is seen; -1 if it never comes.
    task automatic wait_done(input int sel, output int cycles);
        cycles = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (get_done(sel)) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] w0_snap;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy4, done4, valid4} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags4: got %b want 000", {busy4, done4, valid4});
        end
        n_checks++;
        if (exp4 !== '0) begin n_fail++; $display("FAIL reset_bus4: bus not zero"); end
        n_checks++;
        if (exp6 !== '0 || exp8 !== '0) begin n_fail++; $display("FAIL reset_bus68: bus not zero"); end
        // reset wins over a simultaneous start
        key4 = KEY_A;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n_checks++;
        if ({busy4, valid4} !== 2'b00) begin
            n_fail++; $display("FAIL reset_with_start: busy,valid got %b want 00", {busy4, valid4});
        end
        w0_snap = get_word(4, 0);
        n_checks++;
        if (w0_snap !== 32'h0) begin
            n_fail++; $display("FAIL reset_with_start_w0: got %h want 00000000", w0_snap);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic check_key_a_words(input string tag);
        logic [31:0] exp_w [12] = '{
            32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
            32'hd6aa74fd, 32'hd2af72fa, 32'hdaa678f1, 32'hd6ab76fe,
            32'h13111d7f, 32'he3944a17, 32'hf307a78b, 32'h4d2b30c5};
        int idx [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 40, 41, 42, 43};
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (get_word(4, idx[k]) !== exp_w[k]) begin
                n_fail++;
                $display("FAIL %s_w%0d: got %h want %h", tag, idx[k], get_word(4, idx[k]), exp_w[k]);
            end
        end
    endtask

    task automatic test_128();
        int lat;
        do_start(4, {128'h0, KEY_A});
        n_checks++;
        if ({busy4, valid4} !== 2'b10) begin
            n_fail++; $display("FAIL 128_busy: busy,valid got %b want 10", {busy4, valid4});
        end
        wait_done(4, lat);
        n_checks++;
        if (lat !== 40) begin n_fail++; $display("FAIL 128_latency: got %0d want 40", lat); end
        n_checks++;
        if ({busy4, valid4} !== 2'b01) begin
            n_fail++; $display("FAIL 128_end_flags: busy,valid got %b want 01", {busy4, valid4});
        end
        check_key_a_words("128");
        tick();
        n_checks++;
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL 128_done_pulse: got %b want 0", done4); end
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (valid4 !== 1'b1) begin n_fail++; $display("FAIL 128_valid_hold: got %b want 1", valid4); end
    endtask

    task automatic test_192();
        int lat;
        logic [31:0] exp_w [6] = '{32'h00010203, 32'h14151617,
            32'ha4970a33, 32'h1a78dc09, 32'hc418c271, 32'he3a41d5d};
        int idx [6] = '{0, 5, 48, 49, 50, 51};
        do_start(6, {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617});
        wait_done(6, lat);
        n_checks++;
        if (lat !== 46) begin n_fail++; $display("FAIL 192_latency: got %0d want 46", lat); end
        n_checks++;
        if (valid6 !== 1'b1) begin n_fail++; $display("FAIL 192_valid: got %b want 1", valid6); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (get_word(6, idx[k]) !== exp_w[k]) begin
                n_fail++;
                $display("FAIL 192_w%0d: got %h want %h", idx[k], get_word(6, idx[k]), exp_w[k]);
            end
        end
    endtask

    task automatic test_256();
        int lat;
        logic [31:0] exp_w [6] = '{32'h00010203, 32'h1c1d1e1f,
            32'h24fc79cc, 32'hbf0979e9, 32'h371ac23c, 32'h6d68de36};
        int idx [6] = '{0, 7, 56, 57, 58, 59};
        do_start(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        wait_done(8, lat);
        n_checks++;
        if (lat !== 52) begin n_fail++; $display("FAIL 256_latency: got %0d want 52", lat); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (get_word(8, idx[k]) !== exp_w[k]) begin
                n_fail++;
                $display("FAIL 256_w%0d: got %h want %h", idx[k], get_word(8, idx[k]), exp_w[k]);
            end
        end
    endtask

    task automatic test_start_mid_run();
        int first_done = -1;
        int n_done     = 0;
        do_start(4, {128'h0, KEY_A});
        for (int n = 1; n <= 10; n++) tick();
        key4   = KEY_B;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL midstart_busy: got %b want 1", busy4); end
        for (int n = 12; n <= 90; n++) begin
            tick();
            if (done4) begin
                n_done++;
                if (first_done < 0) first_done = n;
            end
        end
        n_checks++;
        if (first_done !== 40) begin
            n_fail++; $display("FAIL midstart_latency: got %0d want 40", first_done);
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL midstart_done_count: got %0d want 1", n_done); end
        check_key_a_words("midstart");
    endtask

    task automatic test_reset_mid_run();
        int lat;
        do_start(4, {128'h0, KEY_A});
        for (int n = 1; n <= 20; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy4, done4, valid4} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_flags: got %b want 000", {busy4, done4, valid4});
        end
        n_checks++;
        if (exp4 !== '0) begin n_fail++; $display("FAIL midreset_bus: bus not zero"); end
        for (int n = 0; n < 45; n++) begin
            tick();
            n_checks++;
            if (done4 !== 1'b0) begin n_fail++; $display("FAIL midreset_spurious_done: got 1 want 0"); end
        end
        do_start(4, {128'h0, KEY_A});
        wait_done(4, lat);
        n_checks++;
        if (lat !== 40) begin n_fail++; $display("FAIL midreset_latency: got %0d want 40", lat); end
        check_key_a_words("midreset");
    endtask

    task automatic test_restart_on_done();
        int lat;
        logic [31:0] exp_w [12] = '{
            32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
            32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605,
            32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
        int idx [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 40, 41, 42, 43};
        do_start(4, {128'h0, KEY_A});
        wait_done(4, lat);
        n_checks++;
        if (lat !== 40) begin n_fail++; $display("FAIL restart_first_latency: got %0d want 40", lat); end
        // done is high now: start with the new key in this very cycle
        do_start(4, {128'h0, KEY_B});
        key4 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        n_checks++;
        if ({busy4, valid4} !== 2'b10) begin
            n_fail++; $display("FAIL restart_valid_drop: busy,valid got %b want 10", {busy4, valid4});
        end
        wait_done(4, lat);
        n_checks++;
        if (lat !== 40) begin n_fail++; $display("FAIL restart_second_latency: got %0d want 40", lat); end
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (get_word(4, idx[k]) !== exp_w[k]) begin
                n_fail++;
                $display("FAIL restart_w%0d: got %h want %h", idx[k], get_word(4, idx[k]), exp_w[k]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        key4   = '0;
        key6   = '0;
        key8   = '0;
        test_reset();
        test_128();
        test_192();
        test_256();
        test_start_mid_run();
        test_reset_mid_run();
        test_restart_on_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
